ps2_mouse_packet_rx: RTL and testbench

//  Front end for the PS/2 mouse path: conditions raw ps2_clk/ps2_data and receives 11-bit frames
//  (start, 8 data LSB-first, odd parity, stop). Assembles 3-byte mouse packets and presents

---
 rtl/ps2_mouse_packet_rx_pkg.sv | 19 +
 rtl/ps2_mouse_packet_rx_if.sv | 24 ++
 rtl/ps2_mouse_packet_rx_byte_rx.sv | 152 +++++++++++++++
 rtl/ps2_mouse_packet_rx.sv | 100 ++++++++++
 tb/tb_ps2_mouse_packet_rx.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_mouse_packet_rx_pkg.sv
// Shared types, constants and helpers for the PS/2 mouse receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam int PKT_BYTES      = 3;
  localparam int BYTE0_SYNC_BIT = 3;

  // Converts a duration in microseconds to a count of system clock cycles.
  function automatic int us_to_cycles(input longint clk_hz, input longint us);
    return int'((clk_hz * us) / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_mouse_packet_rx_if.sv
// PS/2 line inputs and decoded mouse packet outputs.
// slave: the receiver; master: the PS/2 device side plus the packet consumer.
interface ps2_mouse_packet_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       packet_valid;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       x_ovf;
  logic       y_ovf;
  logic       frame_err;
  logic       sync_err;

  modport master (
    output ps2_clk, ps2_data,
    input  packet_valid, buttons, dx, dy, x_ovf, y_ovf, frame_err, sync_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output packet_valid, buttons, dx, dy, x_ovf, y_ovf, frame_err, sync_err
  );
endinterface

// File: rtl/ps2_mouse_packet_rx_byte_rx.sv
// Line conditioning and 11-bit PS/2 frame receiver.
//
//  state  | meaning
//  IDLE   | waiting for a start bit (data 0 on a falling clock edge)
//  DATA   | shifting in 8 data bits, LSB first
//  PARITY | checking odd parity over data and parity bit
//  STOP   | checking stop bit, then emit byte or frame error
module ps2_byte_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int FILTER_LEN     = 8,
  parameter int BIT_TIMEOUT_US = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int BIT_TO_CYC = us_to_cycles(CLK_HZ, BIT_TIMEOUT_US);
  localparam int BTW        = $clog2(BIT_TO_CYC + 1);
  localparam int FCW        = $clog2(FILTER_LEN + 1);

  logic           r_clk_meta, r_clk_sync, r_data_meta, r_data_sync;
  logic           r_clk_filt, r_clk_filt_d, r_data_filt;
  logic [FCW-1:0] r_clk_cnt, r_data_cnt;
  frame_state_t   r_state;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_par_ok;
  logic [BTW-1:0] r_timer;
  logic [7:0]     r_byte;
  logic           r_byte_valid;
  logic           r_frame_err;
  logic           w_sample_en;

  // Two-flop synchronisers on the raw asynchronous lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= i_ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_data_meta <= i_ps2_data;
      r_data_sync <= r_data_meta;
    end
  end

  // Clock glitch filter: level follows only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_filt <= 1'b1;
      r_clk_cnt  <= '0;
    end else if (r_clk_sync == r_clk_filt) begin
      r_clk_cnt <= '0;
    end else if (r_clk_cnt == FCW'(FILTER_LEN - 1)) begin
      r_clk_filt <= r_clk_sync;
      r_clk_cnt  <= '0;
    end else begin
      r_clk_cnt <= r_clk_cnt + FCW'(1);
    end
  end

  // Data filter, same rule, keeps data aligned with the filtered clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_filt <= 1'b1;
      r_data_cnt  <= '0;
    end else if (r_data_sync == r_data_filt) begin
      r_data_cnt <= '0;
    end else if (r_data_cnt == FCW'(FILTER_LEN - 1)) begin
      r_data_filt <= r_data_sync;
      r_data_cnt  <= '0;
    end else begin
      r_data_cnt <= r_data_cnt + FCW'(1);
    end
  end

  // Delayed filtered clock for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) r_clk_filt_d <= 1'b1;
    else       r_clk_filt_d <= r_clk_filt;
  end

  assign w_sample_en = r_clk_filt_d & ~r_clk_filt;

  // Frame FSM with bit timeout; a sample_en on the expiry cycle takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_ok     <= 1'b0;
      r_timer      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_sample_en) begin
        r_timer <= BTW'(BIT_TO_CYC - 1);
        case (r_state)
          IDLE: begin
            if (!r_data_filt) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end
          end
          DATA: begin
            r_shift   <= {r_data_filt, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par_ok <= ^{r_shift, r_data_filt};
            r_state  <= STOP;
          end
          STOP: begin
            if (r_par_ok && r_data_filt) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE) begin
        if (r_timer == '0) begin
          r_frame_err <= 1'b1;
          r_state     <= IDLE;
        end else begin
          r_timer <= r_timer - BTW'(1);
        end
      end
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse packet receiver: assembles 3-byte packets and decodes buttons and motion.
module ps2_mouse_packet_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int FILTER_LEN     = 8,
  parameter int BIT_TIMEOUT_US = 200,
  parameter int PKT_TIMEOUT_US = 20000
) (
  input  logic                 clk,
  input  logic                 reset,
  ps2_mouse_packet_rx_if.slave bus
);

  localparam int         PKT_TO_CYC = us_to_cycles(CLK_HZ, PKT_TIMEOUT_US);
  localparam int         PTW        = $clog2(PKT_TO_CYC + 1);
  localparam logic [1:0] IDX_LAST   = 2'(PKT_BYTES - 1);

  logic [7:0]     w_byte;
  logic           w_byte_valid;
  logic           w_frame_err;
  logic [1:0]     r_idx;
  logic [PTW-1:0] r_pkt_timer;
  logic [7:0]     r_b0, r_b1;
  logic           r_packet_valid, r_sync_err;
  logic [2:0]     r_buttons;
  logic [8:0]     r_dx, r_dy;
  logic           r_x_ovf, r_y_ovf;

  ps2_byte_rx #(
    .CLK_HZ         (CLK_HZ),
    .FILTER_LEN     (FILTER_LEN),
    .BIT_TIMEOUT_US (BIT_TIMEOUT_US)
  ) u_byte_rx (
    .clk          (clk),
    .reset        (reset),
    .i_ps2_clk    (bus.ps2_clk),
    .i_ps2_data   (bus.ps2_data),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  // Packet index FSM, inter-byte timeout and registered decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx          <= '0;
      r_pkt_timer    <= '0;
      r_b0           <= '0;
      r_b1           <= '0;
      r_packet_valid <= 1'b0;
      r_sync_err     <= 1'b0;
      r_buttons      <= '0;
      r_dx           <= '0;
      r_dy           <= '0;
      r_x_ovf        <= 1'b0;
      r_y_ovf        <= 1'b0;
    end else begin
      r_packet_valid <= 1'b0;
      r_sync_err     <= 1'b0;
      if (w_frame_err) begin
        r_idx <= '0;
      end else if (w_byte_valid) begin
        r_pkt_timer <= PTW'(PKT_TO_CYC - 1);
        if (r_idx == 2'd0) begin
          if (w_byte[BYTE0_SYNC_BIT]) begin
            r_b0  <= w_byte;
            r_idx <= 2'd1;
          end else begin
            r_sync_err <= 1'b1;
          end
        end else if (r_idx == IDX_LAST) begin
          r_buttons      <= r_b0[2:0];
          r_dx           <= {r_b0[4], r_b1};
          r_dy           <= {r_b0[5], w_byte};
          r_x_ovf        <= r_b0[6];
          r_y_ovf        <= r_b0[7];
          r_packet_valid <= 1'b1;
          r_idx          <= '0;
        end else begin
          r_b1  <= w_byte;
          r_idx <= r_idx + 2'd1;
        end
      end else if (r_idx != 2'd0) begin
        if (r_pkt_timer == '0) r_idx <= '0;
        else                   r_pkt_timer <= r_pkt_timer - PTW'(1);
      end
    end
  end

  assign bus.packet_valid = r_packet_valid;
  assign bus.buttons      = r_buttons;
  assign bus.dx           = r_dx;
  assign bus.dy           = r_dy;
  assign bus.x_ovf        = r_x_ovf;
  assign bus.y_ovf        = r_y_ovf;
  assign bus.frame_err    = w_frame_err;
  assign bus.sync_err     = r_sync_err;

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Scoreboard bench for ps2_mouse_packet_rx with a PS/2 device-side driver.
`timescale 1ns/1ps
module tb_ps2_mouse_packet_rx;

  localparam int CLK_HZ = 1_000_000;

  typedef struct {
    logic [2:0] buttons;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       xo;
    logic       yo;
  } pkt_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   exp_ferr = 0, exp_serr = 0, obs_ferr = 0, obs_serr = 0;
  pkt_t exp_q[$];
  logic [7:0] mq[$];
  pkt_t mon_e;

  ps2_mouse_packet_rx_if bus();

  ps2_mouse_packet_rx #(
    .CLK_HZ         (CLK_HZ),
    .FILTER_LEN     (8),
    .BIT_TIMEOUT_US (200),
    .PKT_TIMEOUT_US (2000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #500 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Device side: data set while clock high, 80-cycle bit period.
  task automatic drive_bit(input logic b);
    bus.ps2_data = b;
    cyc(20);
    bus.ps2_clk = 1'b0;
    cyc(40);
    bus.ps2_clk = 1'b1;
    cyc(20);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(f[i]);
    bus.ps2_data = 1'b1;
    cyc(100);
  endtask

  // Reference: packets as a list of bytes; byte0 must carry the sync bit.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    pkt_t p;
    if (!ok) begin
      exp_ferr++;
      mq.delete();
    end else if (mq.size() == 0 && b[3] == 1'b0) begin
      exp_serr++;
    end else begin
      mq.push_back(b);
      if (mq.size() == 3) begin
        p.buttons = mq[0][2:0];
        p.dx      = {mq[0][4], mq[1]};
        p.dy      = {mq[0][5], mq[2]};
        p.xo      = mq[0][6];
        p.yo      = mq[0][7];
        exp_q.push_back(p);
        mq.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b, 1'b1);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic end_test(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      cyc(1);
      n++;
    end
    check({nm, "_pending"}, exp_q.size(), 0);
    check({nm, "_frame_err"}, obs_ferr, exp_ferr);
    check({nm, "_sync_err"}, obs_serr, exp_serr);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_valid"}, bus.packet_valid, 0);
    check({nm, "_buttons"}, bus.buttons, 0);
    check({nm, "_dx"}, bus.dx, 0);
    check({nm, "_dy"}, bus.dy, 0);
    check({nm, "_ovf"}, {bus.x_ovf, bus.y_ovf}, 0);
    check({nm, "_errs"}, {bus.frame_err, bus.sync_err}, 0);
  endtask

  // Monitor: compares every packet_valid against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.packet_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_packet: got dx=%0h dy=%0h expected none", bus.dx, bus.dy);
        end else begin
          mon_e = exp_q.pop_front();
          check("pkt_buttons", bus.buttons, mon_e.buttons);
          check("pkt_dx", bus.dx, mon_e.dx);
          check("pkt_dy", bus.dy, mon_e.dy);
          check("pkt_x_ovf", bus.x_ovf, mon_e.xo);
          check("pkt_y_ovf", bus.y_ovf, mon_e.yo);
        end
      end
      if (bus.frame_err) obs_ferr++;
      if (bus.sync_err) obs_serr++;
    end
  end

  initial begin
    #150_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r1, r2;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset = 1'b1;
    cyc(5);
    @(negedge clk);
    check_zero("reset");
    #1;
    reset = 1'b0;
    cyc(50);

    send_pkt(8'h28, 8'h05, 8'hFB);
    end_test("t1_basic");

    send_pkt(8'h39, 8'h80, 8'h7F);
    end_test("t2_negative");

    send_byte(8'h08);
    model_byte(8'h22, 1'b0);
    send_frame(8'h22, 1'b1, 11);
    send_pkt(8'h0A, 8'h10, 8'hF0);
    end_test("t3_parity");

    send_byte(8'h00);
    send_pkt(8'h08, 8'h01, 8'h01);
    end_test("t4_sync");

    model_byte(8'h33, 1'b0);
    send_frame(8'h33, 1'b0, 4);
    cyc(300);
    send_pkt(8'hC9, 8'h7E, 8'h81);
    end_test("t5_bit_timeout");

    send_byte(8'h18);
    cyc(2500);
    mq.delete();
    send_pkt(8'h0C, 8'h44, 8'h55);
    end_test("t6_pkt_timeout");

    bus.ps2_data = 1'b0;
    cyc(5);
    bus.ps2_clk = 1'b0;
    cyc(3);
    bus.ps2_clk = 1'b1;
    cyc(20);
    bus.ps2_data = 1'b1;
    cyc(20);
    send_frame(8'h5A, 1'b0, 4);
    reset = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    mq.delete();
    cyc(3);
    @(negedge clk);
    check_zero("mid_reset");
    #1;
    reset = 1'b0;
    cyc(50);
    send_pkt(8'h0F, 8'h02, 8'hFE);
    end_test("t7_glitch_reset");

    for (int i = 0; i < 4; i++) begin
      r0 = 8'($urandom_range(0, 255)) | 8'h08;
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      send_pkt(r0, r1, r2);
    end
    end_test("t8_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
